mix_add_char: RTL and testbench
===============================

MIX_ADD_CHAR -- requirements
Module: mix_add_char

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 add_start  input  1  one-cycle pulse that starts an addition.
REQ-004 add_in1  input  31  augend MIX word: bit 30 is the sign (1 = negative); bits 29:0 are the binary magnitude (five 6-bit bytes).
REQ-005 add_in2  input  31  addend MIX word, same format as add_in1.
REQ-006 add_stop  output  1  one-cycle pulse; add_out and add_overflow are valid in this cycle.
REQ-007 add_out  output  31  sum, as a MIX word.
REQ-008 add_overflow  output  1  set when the magnitude carries out of 30 bits.
REQ-009 char_start  input  1  one-cycle pulse that starts a CHAR conversion.
REQ-010 char_in  input  30  unsigned binary magnitude to convert.
REQ-011 char_stop  output  1  one-cycle pulse; char_out is valid in this cycle.
REQ-012 char_out  output  60  ten 6-bit MIX character codes; bits 59:54 hold the most significant decimal digit.

Function
REQ-013 The add unit and the char unit SHALL be independent and SHALL be able to run concurrently.
REQ-014 Add timing:
- start pulse at edge N;
- add_in1 and add_in2 sampled at edge N+1;
- add_stop high for exactly one cycle after edge N+2.
REQ-015 Add, equal signs:
- magnitude = (m1+m2) mod 2^30;
- sign = sign1;
- add_overflow = carry out of bit 29.
REQ-016 Add, unequal signs:
- magnitude = |m1−m2|;
- sign = sign of the larger magnitude;
- add_overflow = 0.
REQ-017 Add, unequal signs with m1 == m2: result SHALL be magnitude 0 with sign = sign1 (MIX rule: a zero result keeps the sign of rA).
REQ-018 add_start while the add unit is busy (cycles N+1, N+2) SHALL be ignored.
REQ-019 add_out and add_overflow SHALL hold their last values until the next add_stop.
REQ-020 CHAR: char_in SHALL be sampled at the char_start edge and converted to ten decimal digits, zero-padded on the left.
REQ-021 Each digit d SHALL be encoded as 6-bit code 30+d: '0' = 30 through '9' = 39.
REQ-022 The largest input, 2^30−1 = 1073741823, SHALL convert correctly.
REQ-023 CHAR latency SHALL be fixed for every input value:
- sequential double-dabble, one shift per cycle over 30 input bits;
- char_stop high exactly 31 cycles after the char_start edge.
REQ-024 char_start while the char unit is busy SHALL be ignored.
REQ-025 char_out SHALL hold its last value until the next char_stop.
REQ-026 Intermediate BCD values SHALL never appear on char_out.
REQ-027 add_start and char_start asserted in the same cycle SHALL both be accepted.

Reset
REQ-028 While reset is high, the following outputs SHALL be 0: add_stop, char_stop, add_out, add_overflow, char_out.
REQ-029 While reset is high, both units SHALL be idle.
REQ-030 Reset SHALL take priority over start.
REQ-031 A start pulse in the same cycle as reset SHALL be ignored.
REQ-032 Reset asserted mid-operation SHALL abort the operation; no stop pulse SHALL follow.

Verification
REQ-033 add_in1 = +5, add_in2 = +7 -> add_out = +12 (sign 0), add_overflow = 0, add_stop exactly two cycles after the start edge.
REQ-034 add_in1 = −5, add_in2 = +7 -> add_out = +2; add_in1 = +5, add_in2 = −7 -> add_out = −2; add_overflow = 0 in both cases.
REQ-035 add_in1 = +1073741823, add_in2 = +1 -> add_out = +0, add_overflow = 1; add_in1 = −3, add_in2 = +3 -> add_out = −0 (bit 30 set), add_overflow = 0.
REQ-036 char_in = 12977 -> char_out codes, MSB first, = 30,30,30,30,30,31,32,39,37,37; char_in = 1073741823 -> 31,30,37,33,37,34,31,38,32,33; char_stop 31 cycles after the start edge.
REQ-037 Second char_start 5 cycles after the first -> ignored; exactly one char_stop, carrying the first input's result.
REQ-038 Reset asserted at cycle 10 of a CHAR conversion -> char_out = 0 and no char_stop; a subsequent conversion completes normally.

Source files
------------

// File: rtl/mix_add_char_if.sv
// mix_add_char_if: bundles the add and CHAR handshakes of mix_add_char.
//   add_start/add_in1/add_in2 -> add_stop/add_out/add_overflow
//   char_start/char_in        -> char_stop/char_out
//   master drives starts and operands; slave (the unit) drives results.
interface mix_add_char_if;
    logic        add_start;
    logic [30:0] add_in1;
    logic [30:0] add_in2;
    logic        add_stop;
    logic [30:0] add_out;
    logic        add_overflow;
    logic        char_start;
    logic [29:0] char_in;
    logic        char_stop;
    logic [59:0] char_out;

    modport master (
        output add_start, add_in1, add_in2, char_start, char_in,
        input  add_stop, add_out, add_overflow, char_stop, char_out
    );

    modport slave (
        input  add_start, add_in1, add_in2, char_start, char_in,
        output add_stop, add_out, add_overflow, char_stop, char_out
    );
endinterface

// File: rtl/mix_add_char.sv
// mix_add_char: MIX signed-magnitude adder and binary-to-CHAR converter.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts both units
//   bus   : add path (start, two 31-bit MIX words -> stop, sum, overflow)
//           char path (start, 30-bit magnitude -> stop, ten 6-bit codes)
// The two units share nothing and run concurrently.
module mix_add_char (
    input  logic             clk,
    input  logic             reset,
    mix_add_char_if.slave    bus
);
    typedef enum logic [1:0] {A_IDLE, A_LOAD, A_CALC} add_state_t;
    typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_OUT} char_state_t;

    add_state_t  add_state, add_next;
    char_state_t char_state, char_next;

    logic        add_load, add_fire;
    logic [30:0] op1, op2;
    logic [30:0] add_res;
    logic        add_ovf;
    logic [30:0] add_out_q;
    logic        add_ovf_q, add_stop_q;

    logic        c_load, c_shift, c_fire;
    logic [29:0] bin;
    logic [39:0] bcd, bcd_adj;
    logic [4:0]  cnt;
    logic [59:0] codes;
    logic [59:0] char_out_q;
    logic        char_stop_q;

    assign bus.add_stop     = add_stop_q;
    assign bus.add_out      = add_out_q;
    assign bus.add_overflow = add_ovf_q;
    assign bus.char_stop    = char_stop_q;
    assign bus.char_out     = char_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            add_state  <= A_IDLE;
            char_state <= C_IDLE;
        end else begin
            add_state  <= add_next;
            char_state <= char_next;
        end
    end

    // Operands are captured one cycle after the start pulse, result one cycle later.
    always_comb begin
        add_next = add_state;
        add_load = 1'b0;
        add_fire = 1'b0;
        case (add_state)
            A_IDLE: add_next = bus.add_start ? A_LOAD : A_IDLE;
            A_LOAD: begin
                add_load = 1'b1;
                add_next = A_CALC;
            end
            A_CALC: begin
                add_fire = 1'b1;
                add_next = A_IDLE;
            end
            default: add_next = A_IDLE;
        endcase
    end

    // Signed-magnitude add; a zero difference keeps the sign of the augend.
    always_comb begin
        logic [30:0] s;
        s = {1'b0, op1[29:0]} + {1'b0, op2[29:0]};
        add_ovf = 1'b0;
        if (op1[30] == op2[30]) begin
            add_res = {op1[30], s[29:0]};
            add_ovf = s[30];
        end else if (op2[29:0] > op1[29:0]) begin
            add_res = {op2[30], op2[29:0] - op1[29:0]};
        end else begin
            add_res = {op1[30], op1[29:0] - op2[29:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op1        <= '0;
            op2        <= '0;
            add_out_q  <= '0;
            add_ovf_q  <= 1'b0;
            add_stop_q <= 1'b0;
        end else begin
            add_stop_q <= add_fire;
            if (add_load) begin
                op1 <= bus.add_in1;
                op2 <= bus.add_in2;
            end
            if (add_fire) begin
                add_out_q <= add_res;
                add_ovf_q <= add_ovf;
            end
        end
    end

    // CHAR: load, 30 shift cycles, one publish cycle -> stop 31 cycles after start.
    always_comb begin
        char_next = char_state;
        c_load    = 1'b0;
        c_shift   = 1'b0;
        c_fire    = 1'b0;
        case (char_state)
            C_IDLE: begin
                c_load    = bus.char_start;
                char_next = bus.char_start ? C_SHIFT : C_IDLE;
            end
            C_SHIFT: begin
                c_shift   = 1'b1;
                char_next = (cnt == 5'd29) ? C_OUT : C_SHIFT;
            end
            C_OUT: begin
                c_fire    = 1'b1;
                char_next = C_IDLE;
            end
            default: char_next = C_IDLE;
        endcase
    end

    // Double-dabble correction: digits of 5 or more get +3 before each shift.
    always_comb begin
        bcd_adj = '0;
        codes   = '0;
        for (int i = 0; i < 10; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
            codes[6*i +: 6]   = 6'd30 + {2'b00, bcd[4*i +: 4]};
        end
    end

    // char_out only changes in the publish cycle, so partial BCD never leaks out.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            char_out_q  <= '0;
            char_stop_q <= 1'b0;
        end else begin
            char_stop_q <= c_fire;
            if (c_load) begin
                bin <= bus.char_in;
                bcd <= '0;
                cnt <= '0;
            end
            if (c_shift) begin
                bcd <= {bcd_adj[38:0], bin[29]};
                bin <= {bin[28:0], 1'b0};
                cnt <= cnt + 5'd1;
            end
            if (c_fire) char_out_q <= codes;
        end
    end
endmodule

// File: tb/tb_mix_add_char.sv
// tb_mix_add_char: table, random and sequence checks for mix_add_char.
module tb_mix_add_char;
    logic clk;
    logic reset;
    mix_add_char_if bus();

    mix_add_char dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [30:0] a;
        logic [30:0] b;
        logic [30:0] sum;
        logic        ovf;
    } add_vec_t;

    typedef struct {
        logic [29:0] v;
        logic [59:0] codes;
    } char_vec_t;

    int checks = 0;
    int errors = 0;
    int cyc, n_add, n_char, at_add, at_char;
    logic [30:0] cap_add;
    logic        cap_ovf;
    logic [59:0] cap_char;

    add_vec_t  avec [10];
    char_vec_t cvec [3];

    function automatic logic [30:0] mw(input logic s, input int unsigned m);
        logic [31:0] t;
        t = m;
        return {s, t[29:0]};
    endfunction

    // Reference: signed arithmetic on the MIX values themselves.
    function automatic logic [31:0] add_model(input logic [30:0] x, input logic [30:0] y);
        longint lim, m1, m2, t;
        lim = longint'(1) << 30;
        m1 = longint'(x[29:0]);
        m2 = longint'(y[29:0]);
        if (x[30] == y[30]) begin
            t = m1 + m2;
            return {t >= lim, x[30], 30'(t % lim)};
        end
        t = (x[30] ? -m1 : m1) + (y[30] ? -m2 : m2);
        if (t > 0) return {1'b0, 1'b0, 30'(t)};
        if (t < 0) return {1'b0, 1'b1, 30'(-t)};
        return {1'b0, x[30], 30'd0};
    endfunction

    // Reference: repeated division by ten, least significant digit first.
    function automatic logic [59:0] char_model(input logic [29:0] v);
        logic [59:0] r;
        int unsigned n;
        n = v;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[6*i +: 6] = 6'(30 + n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_tally();
        cyc = -1;
        n_add = 0;
        n_char = 0;
        at_add = -1;
        at_char = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.add_stop) begin
            n_add++;
            at_add = cyc;
            cap_add = bus.add_out;
            cap_ovf = bus.add_overflow;
        end
        if (bus.char_stop) begin
            n_char++;
            at_char = cyc;
            cap_char = bus.char_out;
        end
    endtask

    // Operands are wrong on the start edge and after N+1 so only N+1 sampling works.
    task automatic add_op(input logic [30:0] x, input logic [30:0] y,
                          output logic [30:0] res, output logic ovf, output int lat);
        bus.add_in1 = ~x;
        bus.add_in2 = ~y;
        bus.add_start = 1'b1;
        clear_tally();
        step();
        bus.add_start = 1'b0;
        bus.add_in1 = x;
        bus.add_in2 = y;
        step();
        bus.add_in1 = 31'($urandom);
        bus.add_in2 = 31'($urandom);
        while (n_add == 0 && cyc < 10) step();
        res = cap_add;
        ovf = cap_ovf;
        lat = at_add;
    endtask

    task automatic char_op(input logic [29:0] v, output logic [59:0] res, output int lat);
        bus.char_in = v;
        bus.char_start = 1'b1;
        clear_tally();
        step();
        bus.char_start = 1'b0;
        bus.char_in = 30'($urandom);
        while (n_char == 0 && cyc < 40) step();
        res = cap_char;
        lat = at_char;
    endtask

    initial begin
        logic [30:0] r, x, y;
        logic        o;
        logic [31:0] m;
        logic [59:0] cr, held_char;
        logic [29:0] v;
        int lat;

        avec[0] = '{mw(0, 5),          mw(0, 7),          mw(0, 12),         1'b0};
        avec[1] = '{mw(1, 5),          mw(0, 7),          mw(0, 2),          1'b0};
        avec[2] = '{mw(0, 5),          mw(1, 7),          mw(1, 2),          1'b0};
        avec[3] = '{mw(0, 1073741823), mw(0, 1),          mw(0, 0),          1'b1};
        avec[4] = '{mw(1, 3),          mw(0, 3),          mw(1, 0),          1'b0};
        avec[5] = '{mw(1, 100),        mw(1, 200),        mw(1, 300),        1'b0};
        avec[6] = '{mw(0, 536870912),  mw(0, 536870912),  mw(0, 0),          1'b1};
        avec[7] = '{mw(1, 1073741823), mw(1, 1073741823), mw(1, 1073741822), 1'b1};
        avec[8] = '{mw(0, 0),          mw(1, 0),          mw(0, 0),          1'b0};
        avec[9] = '{mw(0, 1),          mw(1, 1073741823), mw(1, 1073741822), 1'b0};
        cvec[0] = '{30'd12977,      {6'd30, 6'd30, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd39, 6'd37, 6'd37}};
        cvec[1] = '{30'd1073741823, {6'd31, 6'd30, 6'd37, 6'd33, 6'd37, 6'd34, 6'd31, 6'd38, 6'd32, 6'd33}};
        cvec[2] = '{30'd0,          {10{6'd30}}};

        // Reset with both starts held high: outputs zero, starts ignored.
        reset = 1'b1;
        bus.add_start = 1'b1;
        bus.char_start = 1'b1;
        bus.add_in1 = mw(0, 9);
        bus.add_in2 = mw(0, 9);
        bus.char_in = 30'd77;
        clear_tally();
        repeat (3) step();
        check("reset_add_stop", 64'(bus.add_stop), 0);
        check("reset_add_out", 64'(bus.add_out), 0);
        check("reset_add_ovf", 64'(bus.add_overflow), 0);
        check("reset_char_stop", 64'(bus.char_stop), 0);
        check("reset_char_out", 64'(bus.char_out), 0);
        reset = 1'b0;
        bus.add_start = 1'b0;
        bus.char_start = 1'b0;
        clear_tally();
        repeat (40) step();
        check("reset_start_ignored_add", 64'(n_add), 0);
        check("reset_start_ignored_char", 64'(n_char), 0);

        foreach (avec[i]) begin
            add_op(avec[i].a, avec[i].b, r, o, lat);
            check($sformatf("add_vec%0d_out", i), 64'(r), 64'(avec[i].sum));
            check($sformatf("add_vec%0d_ovf", i), 64'(o), 64'(avec[i].ovf));
            check($sformatf("add_vec%0d_lat", i), 64'(lat), 2);
        end

        foreach (cvec[i]) begin
            char_op(cvec[i].v, cr, lat);
            check($sformatf("char_vec%0d_out", i), 64'(cr), 64'(cvec[i].codes));
            check($sformatf("char_vec%0d_lat", i), 64'(lat), 31);
        end

        for (int k = 0; k < 40; k++) begin
            x = 31'($urandom);
            y = (k % 8 == 0) ? {~x[30], x[29:0]} : 31'($urandom);
            if (k % 5 == 1) y[29:0] = 30'h3FFFFFFF - 30'($urandom_range(0, 3));
            m = add_model(x, y);
            add_op(x, y, r, o, lat);
            check("add_rand_out", 64'(r), 64'(m[30:0]));
            check("add_rand_ovf", 64'(o), 64'(m[31]));
        end

        for (int k = 0; k < 15; k++) begin
            v = (k == 0) ? 30'h3FFFFFFF : 30'($urandom);
            char_op(v, cr, lat);
            check("char_rand_out", 64'(cr), 64'(char_model(v)));
            check("char_rand_lat", 64'(lat), 31);
        end

        // add_out holds across a CHAR conversion.
        add_op(mw(1, 40), mw(0, 15), r, o, lat);
        char_op(30'd999, cr, lat);
        check("add_out_hold", 64'(bus.add_out), 64'(mw(1, 25)));

        // add_start held for three edges: only the first is accepted.
        bus.add_in1 = mw(0, 1000);
        bus.add_in2 = mw(1, 1);
        bus.add_start = 1'b1;
        clear_tally();
        step();
        step();
        step();
        bus.add_start = 1'b0;
        while (cyc < 12) step();
        check("add_busy_count", 64'(n_add), 1);
        check("add_busy_lat", 64'(at_add), 2);
        check("add_busy_out", 64'(cap_add), 64'(mw(0, 999)));

        // Both starts in the same cycle.
        x = mw(1, 123456);
        y = mw(1, 654321);
        v = 30'd31415926;
        bus.add_in1 = x;
        bus.add_in2 = y;
        bus.char_in = v;
        bus.add_start = 1'b1;
        bus.char_start = 1'b1;
        clear_tally();
        step();
        bus.add_start = 1'b0;
        bus.char_start = 1'b0;
        while (cyc < 40) step();
        m = add_model(x, y);
        check("conc_add_lat", 64'(at_add), 2);
        check("conc_add_out", 64'(cap_add), 64'(m[30:0]));
        check("conc_char_lat", 64'(at_char), 31);
        check("conc_char_out", 64'(cap_char), 64'(char_model(v)));
        add_op(mw(0, 1), mw(0, 2), r, o, lat);
        check("char_out_hold", 64'(bus.char_out), 64'(char_model(v)));

        // Second char_start 5 cycles after the first is ignored.
        bus.char_in = 30'd12977;
        bus.char_start = 1'b1;
        clear_tally();
        step();
        bus.char_start = 1'b0;
        bus.char_in = 30'd555;
        while (cyc < 4) step();
        bus.char_start = 1'b1;
        step();
        bus.char_start = 1'b0;
        while (cyc < 70) step();
        check("char_busy_count", 64'(n_char), 1);
        check("char_busy_lat", 64'(at_char), 31);
        check("char_busy_out", 64'(cap_char), 64'(cvec[0].codes));

        // Reset at cycle 10 of a conversion aborts it; no stop follows.
        held_char = bus.char_out;
        check("pre_abort_char_out_nonzero", 64'(held_char != 60'd0), 1);
        bus.char_in = 30'd1073741823;
        bus.char_start = 1'b1;
        clear_tally();
        step();
        bus.char_start = 1'b0;
        while (cyc < 9) step();
        reset = 1'b1;
        step();
        check("abort_char_out", 64'(bus.char_out), 0);
        check("abort_char_stop", 64'(bus.char_stop), 0);
        reset = 1'b0;
        while (cyc < 60) step();
        check("abort_no_stop", 64'(n_char), 0);
        char_op(30'd1073741823, cr, lat);
        check("after_abort_out", 64'(cr), 64'(cvec[1].codes));
        check("after_abort_lat", 64'(lat), 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
